// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/ready port plus the
// instruction valid/ack port towards the decoder/datapath.
interface instr_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] pc_out;
  logic            instr_ack;
  logic            branch_taken;
  logic            halted;
  logic [XLEN-1:0] retired_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output instr_valid, instruction, pc_out,
    input  instr_ack, branch_taken,
    output halted, retired_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  instr_valid, instruction, pc_out,
    output instr_ack, branch_taken,
    input  halted, retired_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over request/ready, issues
// over valid/ack and resolves sequential, j, taken beq and halt flow.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [5:0]  OP_J    = 6'h02;
  localparam logic [5:0]  OP_BEQ  = 6'h04;
  localparam logic [5:0]  OP_HALT = 6'h3f;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] branch_target;
  logic [5:0]      opcode;

  // Redirect targets are relative to the issued instruction's own address.
  assign opcode        = instr_q[31:26];
  assign pc4           = pc_out_q + XLEN'(4);
  assign jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_target = pc4 + branch_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (bus.imem_ready) begin
          instr_d  = bus.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          req_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.instr_ack) begin
          cnt_d   = cnt_q + XLEN'(1);
          valid_d = 1'b0;
          if (opcode == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            req_d   = 1'b1;
            state_d = FETCH;
            if (opcode == OP_J) begin
              pc_d = jump_target;
            end else if (opcode == OP_BEQ && bus.branch_taken) begin
              pc_d = branch_target;
            end else begin
              pc_d = pc4;
            end
          end
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req      = req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instruction   = instr_q;
  assign bus.pc_out        = pc_out_q;
  assign bus.halted        = halted_q;
  assign bus.retired_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: expected fetch addresses are queued as each
// instruction is acked and compared when the next request appears.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0020;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit taken);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    if (w[31:26] == 6'h02) return {pc4[31:28], w[25:0], 2'b00};
    if (w[31:26] == 6'h04 && taken) begin
      off = int'($signed(w[15:0]));
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  // One full fetch/issue/retire of word w with the given memory and ack delays.
  task automatic run_instr(input logic [31:0] w, input int waits, input int ack_dly,
                           input bit taken);
    logic [31:0] addr;
    int          n = 0;
    while (bus.imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (bus.imem_req !== 1'b1) begin
      check("req_timeout", 32'(bus.imem_req), 32'd1);
      return;
    end
    addr = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
    check("fetch_addr", bus.imem_addr, addr);
    check("valid_in_fetch", 32'(bus.instr_valid), 32'd0);
    bus.imem_rdata = JUNK;
    for (int i = 0; i < waits; i++) begin
      bus.instr_ack    = 1'b1;
      bus.branch_taken = 1'b1;
      step();
      check("wait_req", 32'(bus.imem_req), 32'd1);
      check("wait_addr", bus.imem_addr, addr);
      check("wait_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.instr_ack    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.imem_ready   = 1'b1;
    bus.imem_rdata   = w;
    step();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = JUNK;
    check("valid_rise", 32'(bus.instr_valid), 32'd1);
    check("req_drop", 32'(bus.imem_req), 32'd0);
    check("instruction", bus.instruction, w);
    check("pc_out", bus.pc_out, addr);
    for (int i = 0; i < ack_dly; i++) begin
      bus.imem_ready = 1'b1;
      bus.imem_rdata = JUNK;
      step();
      check("hold_instr", bus.instruction, w);
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_req", 32'(bus.imem_req), 32'd0);
    end
    bus.imem_ready   = 1'b0;
    bus.instr_ack    = 1'b1;
    bus.branch_taken = taken;
    if (w[31:26] != 6'h3f) exp_addr_q.push_back(model_next(addr, w, taken));
    exp_cnt++;
    step();
    bus.instr_ack    = 1'b0;
    bus.branch_taken = 1'b0;
    check("retired", bus.retired_count, exp_cnt);
    check("valid_fall", 32'(bus.instr_valid), 32'd0);
    if (w[31:26] == 6'h3f) begin
      check("halted_set", 32'(bus.halted), 32'd1);
      check("req_after_halt", 32'(bus.imem_req), 32'd0);
    end else begin
      check("req_after_ack", 32'(bus.imem_req), 32'd1);
      check("halted_clear", 32'(bus.halted), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.imem_ready   = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_ack    = 1'b0;
    bus.branch_taken = 1'b0;
    exp_cnt          = 32'd0;
    step();
    step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_pc_out", bus.pc_out, 32'd0);
    check("rst_count", bus.retired_count, 32'd0);

    // IDLE lasts one cycle: request appears after the first clean edge.
    reset = 1'b0;
    step();
    check("first_req", 32'(bus.imem_req), 32'd1);
    exp_addr_q.push_back(RESET_PC);

    run_instr(NOP, 0, 0, 1'b0);
    run_instr(NOP, 0, 0, 1'b0);
    run_instr(NOP, 0, 0, 1'b0);
    check("count_after_3", bus.retired_count, 32'd3);
    run_instr(NOP, 0, 0, 1'b0);
    run_instr(NOP, 3, 0, 1'b0);          // 0x10 with wait states
    run_instr(32'h0800_0008, 0, 0, 1'b0); // 0x14: j 0x20
    run_instr(32'h1000_FFFE, 0, 0, 1'b1); // 0x20: beq taken -> 0x1C
    run_instr(32'h0800_0008, 0, 0, 1'b0); // 0x1C: j 0x20
    run_instr(32'h1000_FFFE, 0, 0, 1'b0); // 0x20: beq not taken -> 0x24
    run_instr(32'h0800_0010, 0, 0, 1'b0); // 0x24: j 0x40
    run_instr(32'h0800_0100, 0, 0, 1'b0); // 0x40: j 0x400
    run_instr(NOP, 0, 5, 1'b0);           // 0x400 with delayed ack
    run_instr(32'hFC00_0000, 0, 0, 1'b0); // 0x404: halt

    for (int i = 0; i < 10; i++) begin
      bus.instr_ack    = 1'b1;
      bus.branch_taken = 1'b1;
      bus.imem_ready   = 1'(i % 2);
      step();
      check("halt_req", 32'(bus.imem_req), 32'd0);
      check("halt_flag", 32'(bus.halted), 32'd1);
      check("halt_count", bus.retired_count, exp_cnt);
      check("halt_valid", 32'(bus.instr_valid), 32'd0);
    end
    bus.instr_ack    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.imem_ready   = 1'b0;

    // Reset out of HALT, then again while a fetch is pending.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(RESET_PC);
    exp_cnt = 32'd0;
    step();
    check("refetch_req", 32'(bus.imem_req), 32'd1);
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_req", 32'(bus.imem_req), 32'd0);
    check("midrst_halted", 32'(bus.halted), 32'd0);
    check("midrst_count", bus.retired_count, 32'd0);
    check("midrst_valid", 32'(bus.instr_valid), 32'd0);
    reset = 1'b0;
    step();

    run_instr(32'h1000_FFFE, 0, 0, 1'b1); // 0x0: beq taken -> 0xFFFF_FFFC
    run_instr(NOP, 1, 0, 1'b0);           // wraps to 0
    run_instr(32'h0800_0100, 0, 2, 1'b0); // 0x0: j 0x400
    run_instr(32'hFC00_0000, 0, 0, 1'b0); // halt

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
